// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon permutation sequencer: FSM encoding, beat
// geometry, round constants, the 5-bit S-box and the linear-layer rotations.
package ascon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_PERM   = 2'd2,
        ST_UNLOAD = 2'd3
    } seq_state_e;

    localparam int NUM_BEATS = 20;
    localparam int BEAT_W    = 16;

    // Rotation pairs for S0..S4 in the linear diffusion layer
    localparam int unsigned ROT_1 [5] = '{19, 61, 1, 10, 7};
    localparam int unsigned ROT_2 [5] = '{28, 39, 6, 17, 41};

    function automatic logic [7:0] round_const(input logic [3:0] idx);
        return {4'hF - idx, 4'h0 + idx};
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Input/output bit 4 is the S0 lane, bit 0 the S4 lane
    function automatic logic [4:0] sbox(input logic [4:0] x);
        logic [4:0] y;
        case (x)
            5'h00: y = 5'h04;  5'h01: y = 5'h0b;  5'h02: y = 5'h1f;  5'h03: y = 5'h14;
            5'h04: y = 5'h1a;  5'h05: y = 5'h15;  5'h06: y = 5'h09;  5'h07: y = 5'h02;
            5'h08: y = 5'h1b;  5'h09: y = 5'h05;  5'h0a: y = 5'h08;  5'h0b: y = 5'h12;
            5'h0c: y = 5'h1d;  5'h0d: y = 5'h03;  5'h0e: y = 5'h06;  5'h0f: y = 5'h1c;
            5'h10: y = 5'h1e;  5'h11: y = 5'h13;  5'h12: y = 5'h07;  5'h13: y = 5'h0e;
            5'h14: y = 5'h00;  5'h15: y = 5'h0d;  5'h16: y = 5'h11;  5'h17: y = 5'h18;
            5'h18: y = 5'h10;  5'h19: y = 5'h0c;  5'h1a: y = 5'h01;  5'h1b: y = 5'h19;
            5'h1c: y = 5'h16;  5'h1d: y = 5'h0a;  5'h1e: y = 5'h0f;  5'h1f: y = 5'h17;
            default: y = 5'h00;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One full Ascon round (constant addition, S-box layer, linear layer), purely
// combinational; S0 occupies the most significant 64 bits of the state.
module ascon_round
    import ascon_pkg::*;
(
    input  logic [319:0] state_i,
    input  logic [3:0]   idx_i,
    output logic [319:0] state_o
);

    logic [0:4][63:0] x_s;
    logic [0:4][63:0] y_s;
    logic [0:4][63:0] z_s;
    logic [4:0]       col_s;
    logic [4:0]       sb_s;

    // Column-wise S-box over the five lanes, then per-lane diffusion
    always_comb begin
        x_s = state_i;
        x_s[2][7:0] = x_s[2][7:0] ^ round_const(idx_i);
        y_s   = '0;
        z_s   = '0;
        col_s = 5'd0;
        sb_s  = 5'd0;
        for (int b = 0; b < 64; b++) begin
            col_s = {x_s[0][b], x_s[1][b], x_s[2][b], x_s[3][b], x_s[4][b]};
            sb_s  = sbox(col_s);
            y_s[0][b] = sb_s[4];
            y_s[1][b] = sb_s[3];
            y_s[2][b] = sb_s[2];
            y_s[3][b] = sb_s[1];
            y_s[4][b] = sb_s[0];
        end
        for (int w = 0; w < 5; w++) begin
            z_s[w] = y_s[w] ^ ror64(y_s[w], ROT_1[w]) ^ ror64(y_s[w], ROT_2[w]);
        end
        state_o = z_s;
    end

endmodule

// File: rtl/ascon_perm_sequencer.sv
// Loads a 320-bit Ascon state in 16-bit beats, runs p^a or p^b one round per
// cycle, then streams the state back out. ASCON_SEQ_ABSORB_XOR_EN selects XOR-absorb loading.
module ascon_perm_sequencer
    import ascon_pkg::*;
#(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    input  logic        rounds_b,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic [3:0]  round_idx
);

    localparam logic [3:0] START_A = 4'(12 - ROUNDS_A);
    localparam logic [3:0] START_B = 4'(12 - ROUNDS_B);

    seq_state_e   fsm_q;
    logic [319:0] state_q;
    logic [4:0]   cnt_q;
    logic [3:0]   rnd_q;
    logic         rsel_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;
    logic [15:0]  out_data_q;

    logic [319:0]       round_out_s;
    logic               in_acc_s;
    logic               out_acc_s;
    logic [4:0]         load_k_s;
    logic [4:0]         nxt_k_s;
    logic [8:0]         load_lsb_s;
    logic [8:0]         unld_lsb_s;
    logic [BEAT_W-1:0]  load_beat_s;

    ascon_round u_round (
        .state_i (state_q),
        .idx_i   (rnd_q),
        .state_o (round_out_s)
    );

    // Handshakes and beat slice positions; the counter restarts on entering LOAD
    always_comb begin
        in_acc_s  = in_valid && in_ready_q;
        out_acc_s = out_valid_q && out_ready;
        if (fsm_q == ST_LOAD) begin
            load_k_s = cnt_q + 5'd1;
        end else begin
            load_k_s = 5'd0;
        end
        if (cnt_q == 5'd19) begin
            nxt_k_s = 5'd19;
        end else begin
            nxt_k_s = cnt_q + 5'd1;
        end
        load_lsb_s = 9'd304 - {load_k_s, 4'b0000};
        unld_lsb_s = 9'd304 - {nxt_k_s, 4'b0000};
`ifdef ASCON_SEQ_ABSORB_XOR_EN
        load_beat_s = in_data ^ state_q[load_lsb_s +: BEAT_W];
`else
        load_beat_s = in_data;
`endif
    end

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= ST_IDLE;
            state_q     <= 320'd0;
            cnt_q       <= 5'd0;
            rnd_q       <= 4'd0;
            rsel_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= 16'd0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (in_acc_s) begin
                        state_q[load_lsb_s +: BEAT_W] <= load_beat_s;
                        rsel_q <= rounds_b;
                        cnt_q  <= 5'd0;
                        busy_q <= 1'b1;
                        fsm_q  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (in_acc_s) begin
                        state_q[load_lsb_s +: BEAT_W] <= load_beat_s;
                        if (cnt_q == 5'd18) begin
                            cnt_q      <= 5'd0;
                            in_ready_q <= 1'b0;
                            rnd_q      <= rsel_q ? START_B : START_A;
                            fsm_q      <= ST_PERM;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                ST_PERM: begin
                    state_q <= round_out_s;
                    if (rnd_q == 4'd11) begin
                        rnd_q       <= 4'd0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= round_out_s[319 -: BEAT_W];
                        fsm_q       <= ST_UNLOAD;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                ST_UNLOAD: begin
                    if (out_acc_s) begin
                        if (cnt_q == 5'd19) begin
                            cnt_q       <= 5'd0;
                            out_valid_q <= 1'b0;
                            out_data_q  <= 16'd0;
                            busy_q      <= 1'b0;
                            in_ready_q  <= 1'b1;
                            fsm_q       <= ST_IDLE;
                        end else begin
                            cnt_q      <= nxt_k_s;
                            out_data_q <= state_q[unld_lsb_s +: BEAT_W];
                        end
                    end
                end
                default: begin
                    fsm_q       <= ST_IDLE;
                    cnt_q       <= 5'd0;
                    rnd_q       <= 4'd0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    out_data_q  <= 16'd0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign round_idx = rnd_q;

endmodule
